hilo_unit: RTL and testbench

- Downstream consumer of the multiplier inside the ALU/shift/multiply subsystem of the multicycle MIPS datapath.
- Sequences a multiply request and waits for the multiplier's end signal with a timeout.
- Captures the 64-bit product into architectural HI/LO registers.
- Services MTHI/MTLO writes and MFHI/MFLO reads, raising a stall to control while a multiply is in flight.

---
 rtl/hilo_unit.sv | 120 ++++++++++++
 tb/tb_hilo_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_unit.sv
// HI/LO register unit for the multicycle MIPS datapath.
// Follows a multiply from request to completion, with a timeout. Captures the
// 64-bit product into HI/LO and services MTHI/MTLO/MFHI/MFLO.
//
// Handshake: mult_start is a single-cycle request. It is taken only in IDLE.
// endMult qualifies mul, and it is sampled only in WAIT. A HI/LO op that meets
// WAIT raises stall and is dropped. Control holds the op until stall falls.
module hilo_unit #(
    parameter int TIMEOUT = 40
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        endMult,
    input  logic [63:0] mul,
    input  logic [2:0]  hilo_op,
    input  logic [31:0] wr_data,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        start_acc;
    logic        capture;
    logic        expire;
    logic        op_valid;
    logic        wr_hi;
    logic        wr_lo;

    // Decode events that steer state, counter and register updates.
    always_comb begin
        start_acc = (state == IDLE) && mult_start;
        capture   = (state == WAIT) && endMult;
        expire    = (state == WAIT) && !endMult && (cnt == CNT_LAST);
        op_valid  = (hilo_op >= 3'b001) && (hilo_op <= 3'b100);
        wr_hi     = (state != WAIT) && (hilo_op == 3'b001);
        wr_lo     = (state != WAIT) && (hilo_op == 3'b010);
    end

    // State register.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a capture takes priority over a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_acc) state_nxt = WAIT;
            WAIT: begin
                if (capture)     state_nxt = DONE;
                else if (expire) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Wait counter and the sticky timeout flag. A new start clears the flag.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt         <= 6'd0;
            timeout_err <= 1'b0;
        end else if (start_acc) begin
            cnt         <= 6'd0;
            timeout_err <= 1'b0;
        end else if (expire) begin
            timeout_err <= 1'b1;
        end else if ((state == WAIT) && !endMult) begin
            cnt <= cnt + 6'd1;
        end
    end

    // HI/LO registers: product capture in WAIT, move-to writes in any other state.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (capture) begin
            hi_q <= mul[63:32];
            lo_q <= mul[31:0];
        end else begin
            if (wr_hi) hi_q <= wr_data;
            if (wr_lo) lo_q <= wr_data;
        end
    end

    // Read mux and status outputs.
    always_comb begin
        case (hilo_op)
            3'b011:  rd_data = hi_q;
            3'b100:  rd_data = lo_q;
            default: rd_data = 32'd0;
        endcase
        hi_out = hi_q;
        lo_out = lo_q;
        busy   = (state == WAIT);
        done   = (state == DONE);
        stall  = busy && op_valid;
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit. Products are queued when endMult is
// driven, and they are compared against HI/LO in every done cycle.
module tb_hilo_unit;

    localparam int TIMEOUT = 40;

    logic        Clk;
    logic        reset;
    logic        mult_start;
    logic        endMult;
    logic [63:0] mul;
    logic [2:0]  hilo_op;
    logic [31:0] wr_data;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        stall;
    logic        timeout_err;

    logic [63:0] exp_q[$];
    int          vectors;
    int          miscompares;
    logic [31:0] hi_m;
    logic [31:0] lo_m;

    hilo_unit #(.TIMEOUT(TIMEOUT)) dut (
        .Clk         (Clk),
        .reset       (reset),
        .mult_start  (mult_start),
        .endMult     (endMult),
        .mul         (mul),
        .hilo_op     (hilo_op),
        .wr_data     (wr_data),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .rd_data     (rd_data),
        .busy        (busy),
        .done        (done),
        .stall       (stall),
        .timeout_err (timeout_err)
    );

    // Clock and watchdog.
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: every done cycle pops one queued product.
    always @(negedge Clk) begin
        if (done) begin
            if (exp_q.size() == 0) chk("spurious_done", 64'(done), 64'd0);
            else                   chk("capture", {hi_out, lo_out}, exp_q.pop_front());
        end
    end

    task automatic do_write(input logic [2:0] op, input logic [31:0] d);
        hilo_op = op;
        wr_data = d;
        tick();
        if (op == 3'b001) hi_m = d;
        if (op == 3'b010) lo_m = d;
        hilo_op = 3'b000;
    endtask

    // Start a multiply, hold endMult low for wait_cycles WAIT cycles, then capture.
    task automatic run_mult(input int wait_cycles, input logic [63:0] prod);
        int busy_cycles;
        busy_cycles = 0;
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            if (busy) busy_cycles++;
            tick();
        end
        endMult = 1'b1;
        mul     = prod;
        exp_q.push_back(prod);
        if (busy) busy_cycles++;
        tick();
        endMult = 1'b0;
        mul     = 64'd0;
        hi_m    = prod[63:32];
        lo_m    = prod[31:0];
        chk("busy_len", 64'(busy_cycles), 64'(wait_cycles + 1));
        chk("done_pulse", 64'(done), 64'd1);
        chk("timeout_clear", 64'(timeout_err), 64'd0);
        tick();
        chk("done_len", 64'(done), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        hi_m        = 32'd0;
        lo_m        = 32'd0;
        reset       = 1'b1;
        mult_start  = 1'b0;
        endMult     = 1'b0;
        mul         = 64'd0;
        hilo_op     = 3'b000;
        wr_data     = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_rd", 64'(rd_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        tick();

        // MTHI, then MFHI on the next cycle.
        do_write(3'b001, 32'hDEADBEEF);
        hilo_op = 3'b011;
        #1;
        chk("mfhi_rd", 64'(rd_data), 64'hDEADBEEF);
        chk("mfhi_hi", 64'(hi_out), 64'hDEADBEEF);
        chk("mfhi_lo", 64'(lo_out), 64'd0);
        chk("mfhi_busy", 64'(busy), 64'd0);
        chk("idle_stall", 64'(stall), 64'd0);
        hilo_op = 3'b000;

        // Nominal multiply: 33 WAIT cycles, then capture.
        run_mult(33, 64'h0000_0001_FFFF_FFFE);
        chk("nom_hi", 64'(hi_out), 64'h00000001);
        chk("nom_lo", 64'(lo_out), 64'hFFFFFFFE);

        // Timeout: endMult never arrives.
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("to_wait_cycles", 64'(n), 64'(TIMEOUT));
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_hi", 64'(hi_out), 64'(hi_m));
        chk("to_lo", 64'(lo_out), 64'(lo_m));
        tick();
        chk("to_sticky", 64'(timeout_err), 64'd1);
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        chk("to_restart_clr", 64'(timeout_err), 64'd0);
        chk("to_restart_busy", 64'(busy), 64'd1);
        // Let this one expire as well before continuing.
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk("to2_err", 64'(timeout_err), 64'd1);

        // Ops during WAIT: MTLO is dropped, MFLO shows the old LO, and undefined ops do not stall.
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        hilo_op = 3'b010;
        wr_data = 32'h12345678;
        #1;
        chk("wait_mtlo_stall", 64'(stall), 64'd1);
        tick();
        chk("wait_mtlo_drop", 64'(lo_out), 64'(lo_m));
        hilo_op = 3'b100;
        #1;
        chk("wait_mflo_stall", 64'(stall), 64'd1);
        chk("wait_mflo_rd", 64'(rd_data), 64'(lo_m));
        hilo_op = 3'b111;
        #1;
        chk("wait_undef_stall", 64'(stall), 64'd0);
        chk("wait_undef_rd", 64'(rd_data), 64'd0);
        hilo_op = 3'b000;
        endMult = 1'b1;
        mul     = 64'hCAFE_F00D_0BAD_BEEF;
        exp_q.push_back(mul);
        tick();
        endMult = 1'b0;
        hi_m    = 32'hCAFEF00D;
        lo_m    = 32'h0BADBEEF;
        chk("wait_cap_done", 64'(done), 64'd1);
        tick();
        do_write(3'b010, 32'h12345678);
        chk("post_mtlo", 64'(lo_out), 64'h12345678);
        chk("post_mtlo_hi", 64'(hi_out), 64'(hi_m));

        // Reset in the middle of WAIT drops the pending capture.
        mult_start = 1'b1;
        tick();
        mult_start = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b1;
        hi_m  = 32'd0;
        lo_m  = 32'd0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
        endMult = 1'b1;
        mul     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("idle_endmult_hilo", {hi_out, lo_out}, 64'd0);
        chk("idle_endmult_done", 64'(done), 64'd0);
        endMult = 1'b0;
        mul     = 64'd0;

        // MTHI together with mult_start in IDLE.
        hilo_op    = 3'b001;
        wr_data    = 32'hAAAA0000;
        mult_start = 1'b1;
        tick();
        hilo_op    = 3'b000;
        mult_start = 1'b0;
        chk("same_cyc_hi", 64'(hi_out), 64'hAAAA0000);
        chk("same_cyc_busy", 64'(busy), 64'd1);
        repeat (4) tick();
        endMult = 1'b1;
        mul     = 64'h0000_0001_0000_0002;
        exp_q.push_back(mul);
        tick();
        endMult = 1'b0;
        mul     = 64'd0;
        chk("same_cyc_cap", {hi_out, lo_out}, 64'h0000_0001_0000_0002);
        tick();

        // Boundary: endMult arrives on the last count. The capture wins over the timeout.
        run_mult(TIMEOUT - 1, 64'h1357_9BDF_2468_ACE0);
        // Boundary: endMult in the first WAIT cycle.
        run_mult(0, 64'h8000_0000_0000_0001);

        // Random multiplies with random latency.
        for (int k = 0; k < 6; k++) begin
            run_mult(int'($urandom_range(0, TIMEOUT - 1)),
                     {$urandom(), $urandom()});
        end

        tick();
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
